// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// The PARITY state is always encoded so all builds use the same state values.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam int DATA_BITS_DEFAULT = 8;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// The reset value defaults to 1, which suits idle-high serial lines.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line, samples taken at mid-bit.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx import uart_pkg::*; #(
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD),
  parameter int DATA_BITS    = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_nxt;
  logic                 perr_nxt;
`endif

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = data;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
          idx_nxt   = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt     = '0;
          par_bad_nxt = rx_s ^ (^shreg);
          state_nxt   = STOP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt = '0;
          // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
          if (!rx_s) begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_nxt  = 1'b1;
            state_nxt = IDLE;
`endif
          end else begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_nxt;
      parity_err <= perr_nxt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 104 clocks per bit.
// Build with UART_RX_PARITY_EN defined to exercise the parity variant.
module tb_uart_rx;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  int valid_cnt = 0;
  int ferr_cnt  = 0;
  int perr_cnt  = 0;
  int both_cnt  = 0;

  uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) valid_cnt <= valid_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (valid && frame_err) both_cnt <= both_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    wait_clks(CPB);
`endif
    rx = stop_bit;
    wait_clks(CPB);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    wait_clks(3);
    n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_single;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b1);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL single_valid_cnt: got %0d want 1", valid_cnt - v0); end
    n_cmp++; if (data !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h want 55", data); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt - f0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
    wait_clks(CPB);
  endtask

  task automatic test_back_to_back;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h00, 1'b1);
    n_cmp++; if (data !== 8'h00) begin n_fail++; $display("FAIL b2b_data0: got %h want 00", data); end
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL b2b_valid0: got %0d want 1", valid_cnt - v0); end
    send_frame(8'hFF, 1'b1);
    n_cmp++; if (data !== 8'hFF) begin n_fail++; $display("FAIL b2b_data1: got %h want ff", data); end
    n_cmp++; if (valid_cnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid1: got %0d want 2", valid_cnt - v0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL b2b_ferr: got %0d want 0", ferr_cnt - f0); end
    wait_clks(CPB);
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(15);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_mid: got %b want 1", busy); end
    wait_clks(35);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d want 0", valid_cnt - v0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt - f0); end
    wait_clks(CPB);
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    wait_clks(500);
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_cnt: got %0d want 1", ferr_cnt - f0); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL ferr_valid: got %0d want 0", valid_cnt - v0); end
    n_cmp++; if (data !== 8'hFF) begin n_fail++; $display("FAIL ferr_data_held: got %h want ff", data); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break: got %b want 1", busy); end
    rx = 1'b1;
    wait_clks(10);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b want 0", busy); end
    wait_clks(2 * CPB);
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_retrigger: got %0d want 1", ferr_cnt - f0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0;
    logic [7:0] b;
    v0 = valid_cnt; f0 = ferr_cnt;
    b  = 8'h3C;
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = b[3];
    wait_clks(50);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    wait_clks(1);
    reset = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
    rx = 1'b1;
    wait_clks(2 * CPB);
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL rstmid_valid: got %0d want 0", valid_cnt - v0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL rstmid_ferr: got %0d want 0", ferr_cnt - f0); end
    send_frame(8'h81, 1'b1);
    n_cmp++; if (data !== 8'h81) begin n_fail++; $display("FAIL rstmid_data: got %h want 81", data); end
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_valid_after: got %0d want 1", valid_cnt - v0); end
    wait_clks(CPB);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = par_bit;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic test_parity;
    int v0, p0;
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame_par(8'h07, 1'b0);
    n_cmp++; if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL par_bad_perr: got %0d want 1", perr_cnt - p0); end
    n_cmp++; if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL par_bad_valid: got %0d want 0", valid_cnt - v0); end
    n_cmp++; if (data !== 8'h81) begin n_fail++; $display("FAIL par_bad_data: got %h want 81", data); end
    send_frame_par(8'h07, 1'b1);
    n_cmp++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL par_good_valid: got %0d want 1", valid_cnt - v0); end
    n_cmp++; if (data !== 8'h07) begin n_fail++; $display("FAIL par_good_data: got %h want 07", data); end
    n_cmp++; if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL par_good_perr: got %0d want 1", perr_cnt - p0); end
    wait_clks(CPB);
  endtask
`endif

  task automatic test_exclusive;
    n_cmp++; if (both_cnt !== 0) begin n_fail++; $display("FAIL valid_ferr_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
